mac_rr_scheduler: RTL and testbench

- Shares one pipelined multiply-accumulate datapath (DATA_OUT = A*B + C, 8-bit operands, 16-bit result) between NUM_REQ requesters.
- Round-robin arbitration selects at most one request per cycle and issues it into a 2-stage MAC pipeline.
- Each result is returned on a single output channel, tagged with the ID of the requester that issued it.
- Sits between the operand producers and the result consumer, and replaces direct, unshared instantiation of the MAC.

---
 rtl/mac_rr_scheduler.sv | 136 +++++++++++++
 tb/tb_mac_rr_scheduler.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_rr_scheduler.sv
// Round-robin scheduler that shares one 2-stage multiply-accumulate pipeline
// (res = a*b + c) between NUM_REQ requesters. Each result is tagged with the
// ID of the requester that issued it.
module mac_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int OP_W    = 8,
    parameter int RES_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      en_mask,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*OP_W-1:0] req_a,
    input  logic [NUM_REQ*OP_W-1:0] req_b,
    input  logic [NUM_REQ*OP_W-1:0] req_c,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [RES_W-1:0]        res_data,
    output logic [ID_W-1:0]         res_id,
    output logic                    busy
);

    logic                stall_s;
    logic [NUM_REQ-1:0]  eligible_s;
    logic [NUM_REQ-1:0]  grant_s;
    logic                grant_any_s;
    logic [ID_W-1:0]     grant_idx_s;
    logic [ID_W-1:0]     cand_s;
    logic [OP_W-1:0]     sel_a_s;
    logic [OP_W-1:0]     sel_b_s;
    logic [OP_W-1:0]     sel_c_s;
    logic [OP_W-1:0]     a_arr_s [NUM_REQ];
    logic [OP_W-1:0]     b_arr_s [NUM_REQ];
    logic [OP_W-1:0]     c_arr_s [NUM_REQ];

    logic [ID_W-1:0]     ptr_r;
    logic                v1_r;
    logic [OP_W-1:0]     a1_r;
    logic [OP_W-1:0]     b1_r;
    logic [OP_W-1:0]     c1_r;
    logic [ID_W-1:0]     id1_r;
    logic                res_valid_r;
    logic [RES_W-1:0]    res_data_r;
    logic [ID_W-1:0]     res_id_r;

    // A result waiting on the consumer freezes both stages and blocks new grants.
    assign stall_s    = res_valid_r & ~res_ready;
    // Nothing is granted while stalled or while reset is held.
    assign eligible_s = (stall_s || !rst_n) ? {NUM_REQ{1'b0}} : (req_valid & en_mask);

    // Unpack the flat operand buses into per-requester views.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            a_arr_s[i] = req_a[i*OP_W +: OP_W];
            b_arr_s[i] = req_b[i*OP_W +: OP_W];
            c_arr_s[i] = req_c[i*OP_W +: OP_W];
        end
    end

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        grant_s     = {NUM_REQ{1'b0}};
        grant_any_s = 1'b0;
        grant_idx_s = {ID_W{1'b0}};
        cand_s      = {ID_W{1'b0}};
        sel_a_s     = {OP_W{1'b0}};
        sel_b_s     = {OP_W{1'b0}};
        sel_c_s     = {OP_W{1'b0}};
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand_s = ID_W'((int'(ptr_r) + off) % NUM_REQ);
            if (!grant_any_s && eligible_s[cand_s]) begin
                grant_any_s     = 1'b1;
                grant_s[cand_s] = 1'b1;
                grant_idx_s     = cand_s;
                sel_a_s         = a_arr_s[cand_s];
                sel_b_s         = b_arr_s[cand_s];
                sel_c_s         = c_arr_s[cand_s];
            end else begin
                grant_any_s = grant_any_s;
            end
        end
    end

    assign req_ready = grant_s;

    // Priority pointer: remembers the last requester that transferred.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= ID_W'(NUM_REQ - 1);
        end else if (grant_any_s) begin
            ptr_r <= grant_idx_s;
        end
    end

    // Stage 1: capture the granted operands and their requester ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r  <= 1'b0;
            a1_r  <= {OP_W{1'b0}};
            b1_r  <= {OP_W{1'b0}};
            c1_r  <= {OP_W{1'b0}};
            id1_r <= {ID_W{1'b0}};
        end else if (!stall_s) begin
            if (grant_any_s) begin
                v1_r  <= 1'b1;
                a1_r  <= sel_a_s;
                b1_r  <= sel_b_s;
                c1_r  <= sel_c_s;
                id1_r <= grant_idx_s;
            end else begin
                v1_r  <= 1'b0;
            end
        end
    end

    // Stage 2: unsigned multiply-accumulate into the registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_r <= 1'b0;
            res_data_r  <= {RES_W{1'b0}};
            res_id_r    <= {ID_W{1'b0}};
        end else if (!stall_s) begin
            res_valid_r <= v1_r;
            res_data_r  <= RES_W'(a1_r) * RES_W'(b1_r) + RES_W'(c1_r);
            res_id_r    <= id1_r;
        end
    end

    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign res_id    = res_id_r;
    assign busy      = v1_r | res_valid_r;

endmodule

// File: tb/tb_mac_rr_scheduler.sv
// Scoreboard bench for mac_rr_scheduler: a cycle-level reference model predicts
// grants and pipeline occupancy; expected results go into a queue that an
// independent output monitor drains.
`timescale 1ns/1ps
module tb_mac_rr_scheduler;
    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int OPW = 8;
    localparam int RW  = 16;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [RW-1:0]  data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      en_mask;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*OPW-1:0]  req_a, req_b, req_c;
    logic              res_valid;
    logic              res_ready;
    logic [RW-1:0]     res_data;
    logic [IDW-1:0]    res_id;
    logic              busy;

    mac_rr_scheduler #(.NUM_REQ(N), .ID_W(IDW), .OP_W(OPW), .RES_W(RW)) dut (
        .clk(clk), .rst_n(rst_n), .en_mask(en_mask), .req_valid(req_valid),
        .req_ready(req_ready), .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_id(res_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    exp_t sb_q[$];

    // Requester-side state: pending flags and held operands.
    logic [N-1:0]   v_tb;
    logic [OPW-1:0] oa [N];
    logic [OPW-1:0] ob [N];
    logic [OPW-1:0] oc [N];

    // Reference model: one slot being computed, one slot presented at the output.
    bit   m1_v, mo_v;
    exp_t m1_e, mo_e;
    int   m_ptr;
    int   acc_idx;

    logic [RW-1:0]  last_data;
    logic [IDW-1:0] last_id;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int rr_pick(input logic [N-1:0] m, input int p);
        for (int off = 1; off <= N; off++) begin
            int k = (p + off) % N;
            if (m[k]) return k;
        end
        return -1;
    endfunction

    task automatic pack();
        for (int i = 0; i < N; i++) begin
            req_a[i*OPW +: OPW] = oa[i];
            req_b[i*OPW +: OPW] = ob[i];
            req_c[i*OPW +: OPW] = oc[i];
        end
        req_valid = v_tb;
    endtask

    task automatic model_clear();
        m1_v = 1'b0; mo_v = 1'b0; m_ptr = N - 1; acc_idx = -1;
        sb_q.delete();
    endtask

    // Called once per cycle before the rising edge: check, then advance the model.
    task automatic step();
        bit stall;
        int g;
        logic [N-1:0] exp_ready;
        stall = mo_v && !res_ready;
        g = stall ? -1 : rr_pick(v_tb & en_mask, m_ptr);
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        chk("req_ready", req_ready, exp_ready);
        chk("res_valid", res_valid, mo_v);
        chk("busy", busy, m1_v | mo_v);
        if (!stall) begin
            mo_v = m1_v;
            mo_e = m1_e;
            m1_v = (g >= 0);
            if (g >= 0) begin
                m1_e.id   = IDW'(g);
                m1_e.data = RW'(oa[g]) * RW'(ob[g]) + RW'(oc[g]);
                sb_q.push_back(m1_e);
                m_ptr = g;
            end
        end
        acc_idx = g;
    endtask

    // vmode: 0 random new requests, 1 all continuously valid, 2 no new requests.
    // rmode: 0 res_ready=1, 1 random res_ready, 2 res_ready=0.
    task automatic run_cycles(input int n, input int vmode, input int rmode, input bit rmask);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            step();
            @(posedge clk);
            #1;
            if (acc_idx >= 0) v_tb[acc_idx] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!v_tb[i] && (vmode == 1 || (vmode == 0 && $urandom_range(0, 1) == 1))) begin
                    v_tb[i] = 1'b1;
                    oa[i] = OPW'($urandom);
                    ob[i] = OPW'($urandom);
                    oc[i] = OPW'($urandom);
                end
            end
            case (rmode)
                0:       res_ready = 1'b1;
                1:       res_ready = ($urandom_range(0, 3) != 0);
                default: res_ready = 1'b0;
            endcase
            if (rmask) en_mask = N'($urandom);
            pack();
        end
    endtask

    task automatic issue_one(input int id, input logic [OPW-1:0] a, b, c);
        v_tb[id] = 1'b1; oa[id] = a; ob[id] = b; oc[id] = c;
        res_ready = 1'b1;
        pack();
    endtask

    // Output monitor: pops the scoreboard on every accepted result and checks holds.
    initial begin
        bit             prev_hold = 1'b0;
        logic [RW-1:0]  hold_d = '0;
        logic [IDW-1:0] hold_id = '0;
        exp_t           e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    chk("hold_valid", res_valid, 1);
                    chk("hold_data", res_data, hold_d);
                    chk("hold_id", res_id, hold_id);
                end
                if (res_valid && res_ready) begin
                    chk("sb_nonempty", sb_q.size() > 0, 1);
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        chk("res_data", res_data, e.data);
                        chk("res_id", res_id, e.id);
                        last_data = res_data;
                        last_id   = res_id;
                    end
                end
                prev_hold = res_valid && !res_ready;
                hold_d    = res_data;
                hold_id   = res_id;
            end
        end
    end

    initial begin
        rst_n = 1'b0; en_mask = '1; res_ready = 1'b1; v_tb = '0;
        last_data = '0; last_id = '0;
        for (int i = 0; i < N; i++) begin oa[i] = '0; ob[i] = '0; oc[i] = '0; end
        pack();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        rst_n = 1'b1;

        // Single request: 3*4+5
        issue_one(0, 8'd3, 8'd4, 8'd5);
        run_cycles(5, 2, 0, 1'b0);
        chk("single_data", last_data, 16'd17);
        chk("single_id", last_id, 0);

        // Maximum operands on requester 2
        issue_one(2, 8'd255, 8'd255, 8'd255);
        run_cycles(5, 2, 0, 1'b0);
        chk("max_data", last_data, 16'hFF00);
        chk("max_id", last_id, 2);

        // Round-robin with everyone valid
        run_cycles(12, 1, 0, 1'b0);

        // Mask: only 1 and 3, then nothing mid-stream
        en_mask = 4'b1010;
        run_cycles(10, 1, 0, 1'b0);
        en_mask = 4'b0000;
        run_cycles(6, 1, 0, 1'b0);

        // Backpressure: 3 cycles of res_ready low inside a stream
        en_mask = 4'b1111;
        run_cycles(4, 1, 0, 1'b0);
        res_ready = 1'b0;
        run_cycles(3, 1, 2, 1'b0);
        run_cycles(8, 1, 0, 1'b0);

        // Reset while both stages are full
        rst_n = 1'b0;
        #1;
        chk("midrst_res_valid", res_valid, 0);
        chk("midrst_res_data", res_data, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_req_ready", req_ready, 0);
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_cycles(10, 1, 0, 1'b0);

        // Randomised traffic, masks and backpressure
        run_cycles(400, 0, 1, 1'b1);

        // Drain everything still pending or in flight
        en_mask = 4'b1111;
        run_cycles(12, 2, 0, 1'b0);
        chk("drain_empty", sb_q.size(), 0);
        chk("drain_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
